// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions,
// reset values and the excepttype decoder used by the register file.
package cp0_defs;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef struct packed {
    logic       valid;
    logic       bad_addr;
    logic [4:0] code;
  } exc_t;

  function automatic exc_t decode_exc(input logic [31:0] excepttype);
    exc_t e;
    e = '{valid: 1'b1, bad_addr: 1'b0, code: CODE_INT};
    case (excepttype)
      EXC_INT:  e.code = CODE_INT;
      EXC_ADEL: begin e.code = CODE_ADEL; e.bad_addr = 1'b1; end
      EXC_ADES: begin e.code = CODE_ADES; e.bad_addr = 1'b1; end
      EXC_SYS:  e.code = CODE_SYS;
      EXC_BP:   e.code = CODE_BP;
      EXC_RI:   e.code = CODE_RI;
      EXC_OV:   e.code = CODE_OV;
      default:  e.valid = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count advances every second clock, timer interrupt
// latches on a match and is cleared only by a Compare write.
module cp0_timer
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic tick;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= 1'b0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      tick <= ~tick;
      if (count_we)  count <= wdata;
      else if (tick) count <= count + 32'd1;

      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (compare != '0 && count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: Status/Cause/EPC/BadVAddr, exception commit and eret,
// MFC0 read mux with same-cycle MTC0 forwarding.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic [31:0] status, cause, epc, badvaddr, count, compare;
  exc_t        exc;
  logic        is_eret, mtc0_ok;

  assign exc     = decode_exc(excepttype_i);
  assign is_eret = (excepttype_i == EXC_ERET);
  // An exception or eret in the same cycle squashes the MTC0 entirely.
  assign mtc0_ok = we_i && !exc.valid && !is_eret;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_ok && waddr_i == REG_COUNT),
    .compare_we (mtc0_ok && waddr_i == REG_COMPARE),
    .wdata      (data_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RESET;
      cause    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      cause[15:10]    <= {int_i[5] | timer_int_o, int_i[4:0]};
      cause[CAUSE_TI] <= timer_int_o;

      if (exc.valid) begin
        // Nested exceptions keep the EPC/BD of the original fault.
        if (!status[STATUS_EXL]) begin
          epc             <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
          cause[CAUSE_BD] <= in_delayslot_i;
        end
        status[STATUS_EXL] <= 1'b1;
        cause[6:2]         <= exc.code;
        if (exc.bad_addr) badvaddr <= bad_addr_i;
      end else if (is_eret) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (mtc0_ok) begin
        case (waddr_i)
          REG_STATUS: status    <= (status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
          REG_CAUSE:  cause[9:8] <= data_i[9:8];
          REG_EPC:    epc       <= data_i;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr;
      REG_COUNT:    data_o = count;
      REG_COMPARE:  data_o = compare;
      REG_STATUS:   data_o = status;
      REG_CAUSE:    data_o = cause;
      REG_EPC:      data_o = epc;
      REG_PRID:     data_o = PRID_VAL;
      REG_CONFIG:   data_o = CONFIG_VAL;
      default:      data_o = '0;
    endcase
    if (we_i && waddr_i == raddr_i) begin
      case (raddr_i)
        REG_COUNT, REG_COMPARE, REG_EPC: data_o = data_i;
        REG_STATUS: data_o = (status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        REG_CAUSE:  data_o = (cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        default: ;
      endcase
    end
  end

  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = (we_i && waddr_i == REG_EPC) ? data_i : epc;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst, we_i, in_delayslot_i, timer_int_o;
  logic [4:0]  waddr_i, raddr_i;
  logic [5:0]  int_i;
  logic [31:0] data_i, excepttype_i, pc_i, bad_addr_i;
  logic [31:0] data_o, status_o, cause_o, epc_o;

  int n_vec = 0;
  int n_bad = 0;

  cp0_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .raddr_i        (raddr_i),
    .data_i         (data_i),
    .int_i          (int_i),
    .excepttype_i   (excepttype_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .bad_addr_i     (bad_addr_i),
    .data_o         (data_o),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .timer_int_o    (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    raddr_i = addr;
    #1;
    check(tag, data_o, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
    we_i = 1'b1; waddr_i = addr; data_i = val;
    step();
    we_i = 1'b0;
  endtask

  task automatic raise(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
    excepttype_i = et; pc_i = pc; in_delayslot_i = ds; bad_addr_i = bad;
    step();
    excepttype_i = 32'h0; in_delayslot_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       fired;
    logic [31:0] cnt;
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0; int_i = '0;
    excepttype_i = '0; pc_i = '0; in_delayslot_i = 1'b0; bad_addr_i = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check_reg("rst_status", 5'd12, 32'h0040_0000);
    check_reg("rst_cause", 5'd13, 32'h0);
    check_reg("rst_epc", 5'd14, 32'h0);
    check_reg("rst_prid", 5'd15, 32'h0000_4220);
    check("rst_timer", {31'b0, timer_int_o}, 32'h0);

    // Syscall then eret
    raise(32'h8, 32'hbfc0_0100, 1'b0, 32'h0);
    check_reg("sys_epc", 5'd14, 32'hbfc0_0100);
    check_reg("sys_cause", 5'd13, 32'h0000_0020);
    check("sys_status", status_o, 32'h0040_0002);
    raise(32'he, 32'h0, 1'b0, 32'h0);
    check("eret_status", status_o, 32'h0040_0000);
    check("eret_epc", epc_o, 32'hbfc0_0100);
    raise(32'h3, 32'h55, 1'b1, 32'h0);
    check("unk_status", status_o, 32'h0040_0000);
    check("unk_cause", cause_o, 32'h0000_0020);

    // Adel in delay slot, then nested ov
    raise(32'h4, 32'hbfc0_0204, 1'b1, 32'h0000_0003);
    check_reg("adel_epc", 5'd14, 32'hbfc0_0200);
    check_reg("adel_cause", 5'd13, 32'h8000_0010);
    check_reg("adel_badva", 5'd8, 32'h0000_0003);
    raise(32'hc, 32'h0000_1000, 1'b0, 32'h0);
    check_reg("ov_epc", 5'd14, 32'hbfc0_0200);
    check_reg("ov_cause", 5'd13, 32'h8000_0030);
    raise(32'he, 32'h0, 1'b0, 32'h0);

    // Hardware interrupt lines into Cause.IP
    int_i = 6'b000101;
    step();
    check("int_cause", cause_o, 32'h8000_1430);
    int_i = 6'b0;
    step();

    // Timer: Count=0, Compare=10
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd10);
    fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin
      if (timer_int_o) fired = 1'b1;
      else step();
    end
    check("timer_fired", {31'b0, fired}, 32'h1);
    raddr_i = 5'd9;
    #1 cnt = data_o;
    check("timer_count", {31'b0, (cnt == 32'd10 || cnt == 32'd11)}, 32'h1);
    step();
    check("timer_cause", {30'b0, cause_o[30], cause_o[15]}, 32'h3);
    mtc0(5'd11, 32'd100);
    check("timer_clear", {31'b0, timer_int_o}, 32'h0);

    // Status write mask with same-cycle forwarding
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hffff_ffff; raddr_i = 5'd12;
    #1 check("fwd_status", data_o, 32'h0040_ff03);
    step();
    we_i = 1'b0;
    check_reg("status_mask", 5'd12, 32'h0040_ff03);

    // MTC0 EPC dropped by eret in the same cycle
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hdead_beef; excepttype_i = 32'he;
    step();
    we_i = 1'b0; excepttype_i = 32'h0;
    check_reg("drop_epc", 5'd14, 32'hbfc0_0200);
    check("drop_status", status_o, 32'h0040_ff01);

    // Count wrap
    mtc0(5'd9, 32'hffff_ffff);
    check_reg("wrap_pre", 5'd9, 32'hffff_ffff);
    step(); step();
    check_reg("wrap_zero", 5'd9, 32'h0);

    // EPC forwarding to data_o and epc_o
    we_i = 1'b1; waddr_i = 5'd14; raddr_i = 5'd14; data_i = 32'h0000_1234;
    #1;
    check("fwd_data", data_o, 32'h0000_1234);
    check("fwd_epc", epc_o, 32'h0000_1234);
    step();
    we_i = 1'b0;
    check("epc_written", epc_o, 32'h0000_1234);

    // Reset overrides a concurrent exception
    rst = 1'b1; excepttype_i = 32'h8; pc_i = 32'h4444_0000;
    step();
    rst = 1'b0; excepttype_i = 32'h0;
    check("rst2_status", status_o, 32'h0040_0000);
    check("rst2_epc", epc_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
